mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the core's load/store/fetch port. It accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states. It performs a word-wide, byte-strobed access to an internal synchronous SRAM array and returns a single-cycle response pulse. It sits between the multicycle core's memory port and the on-chip RAM, replacing the zero-latency memory model so the core's controller can be exercised against real latency.

## Interface
- DEPTH_WORDS, 16384: number of 32-bit words in the array (64 KiB); power of two, ≥ 2.
- WAIT_CYCLES, 1: extra wait states between accept and access; 0..15.
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; a transfer occurs on a clock edge where req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load/fetch.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, little-endian byte lanes.
- req_wstrb  in  4  byte enables; bit i writes req_wdata[8i+7:8i].
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load data; 0 for stores and errored loads.
- resp_err  out  1  qualifies resp_valid; access was rejected.

## Operation
- States: IDLE, WAIT, RESP.
- Word index = req_addr[AW+1:2], where AW = log2(DEPTH_WORDS).
- IDLE
  - req_ready = 1.
  - On transfer: latch write, address, wdata and wstrb; load cnt = WAIT_CYCLES; go to WAIT.
- WAIT
  - req_ready = 0.
  - If cnt != 0: decrement cnt.
  - If cnt == 0: perform the access at this clock edge and go to RESP.
    - Store: write the enabled bytes only.
    - Load: register the array word into resp_rdata.
- RESP
  - resp_valid = 1 for exactly this cycle; req_ready = 1.
  - On a transfer in this cycle: latch the new request and go to WAIT, giving back-to-back service.
  - Otherwise: go to IDLE.
- Store with req_wstrb = 0: array unchanged; normal response with resp_err = 0.
- Request fields are sampled only on the transfer edge. Later changes to the inputs have no effect.
- No response backpressure: the requester must consume resp_valid in its cycle.

## Timing
- Transfer on edge E. WAIT occupies the cycles following E for WAIT_CYCLES+1 cycles.
  - Store commits on the last WAIT edge.
  - resp_valid is high in cycle WAIT_CYCLES+2 after E.
- Example, WAIT_CYCLES=0: transfer at edge 0, WAIT in cycle 1, RESP in cycle 2.
- Maximum throughput: one request per WAIT_CYCLES+2 cycles.
- Load-after-store to the same word: the store has committed before the load's access edge, so the load returns the new data.
- Reset values: state IDLE, req_ready = 1 (first cycle after reset deasserts), resp_valid = 0, resp_rdata = 0, resp_err = 0, cnt = 0.
- Array contents are not reset.
- Reset in WAIT drops the request; an uncommitted store never writes.
- Reset in RESP suppresses nothing already driven, and no further response is produced.
- Reset has priority over a simultaneous transfer.
- resp_rdata and resp_err hold their last values outside RESP. Checkers must qualify them with resp_valid.

## Configuration
- MEM_RESP_CHECK_EN defined:
  - A request is errored if req_addr[1:0] != 0 or req_addr[31:AW+2] != 0.
  - Errored request: store suppressed, load returns 0, resp_err = 1.
  - Errored requests have the same latency as good ones.
- MEM_RESP_CHECK_EN undefined:
  - req_addr[1:0] and bits above AW+1 are ignored, so addresses alias modulo 4*DEPTH_WORDS.
  - resp_err is tied to 0.

## Test plan
- Reset, then idle:
  - Required: req_ready = 1, resp_valid = 0, resp_rdata = 0 from the first post-reset cycle.
- WAIT_CYCLES=1, store 0xDEADBEEF at 0x100 with wstrb=4'hF, then load 0x100:
  - Store: resp_valid exactly 3 cycles after its transfer, resp_rdata = 0.
  - Load: returns 0xDEADBEEF.
- Store 0x000000AA at 0x100 with wstrb=4'h1, then load 0x100:
  - Required: 0xDEADBEAA.
  - Follow-up store with wstrb=0, then load: still 0xDEADBEAA.
- Back-to-back: hold req_valid with a second load presented during RESP:
  - Required: accepted in the RESP cycle; responses spaced WAIT_CYCLES+2 cycles apart.
- Assert rst one cycle after accepting a store of 0x12345678 to 0x200, then load 0x200:
  - Required: no response for the store; load returns the prior contents.
- With MEM_RESP_CHECK_EN, load 0x102, and separately store to 0x00010000 at DEPTH_WORDS=16384:
  - Required: resp_err = 1, resp_rdata = 0, and the word at 0x0 is unchanged.
  - Without the macro: the store to 0x00010000 aliases to word 0.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - valid/ready memory responder with wait states over a byte-strobed SRAM
// Optional address checking enabled by defining MEM_RESP_CHECK_EN.
module mem_responder #(
  parameter int DEPTH_WORDS = 16384,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [AW-1:0] lat_idx;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wstrb;
  logic        lat_err;

  logic        transfer;
  logic        access;
  logic        mem_we;
  logic        req_err;

  logic [31:0] mem [DEPTH_WORDS];

  assign transfer = req_valid && req_ready;
  assign access   = (state == WAIT) && (cnt == 4'd0);
  // Reset wins over a commit on the same edge so a dropped store never lands.
  assign mem_we   = access && lat_write && !lat_err && !rst;

`ifdef MEM_RESP_CHECK_EN
  assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
`else
  logic unused_addr_bits;
  assign req_err = 1'b0;
  assign unused_addr_bits = ^{req_addr[1:0], req_addr[31:AW+2]};
`endif

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (lat_wstrb[b]) begin
          mem[lat_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      lat_write  <= 1'b0;
      lat_idx    <= '0;
      lat_wdata  <= 32'd0;
      lat_wstrb  <= 4'd0;
      lat_err    <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (transfer) begin
            lat_write <= req_write;
            lat_idx   <= req_addr[AW+1:2];
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
            lat_err   <= req_err;
            cnt       <= WAIT_INIT;
            req_ready <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            resp_valid <= 1'b1;
            resp_err   <= lat_err;
            resp_rdata <= (lat_write || lat_err) ? 32'd0 : mem[lat_idx];
            req_ready  <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          // Accepting here gives back-to-back service without an IDLE bubble.
          if (transfer) begin
            lat_write <= req_write;
            lat_idx   <= req_addr[AW+1:2];
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
            lat_err   <= req_err;
            cnt       <= WAIT_INIT;
            req_ready <= 1'b0;
            state     <= WAIT;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - table-driven bench for mem_responder (MEM_RESP_CHECK_EN aware)
module tb_mem_responder;

  localparam int DW = 16384;
  localparam int WC = 1;
`ifdef MEM_RESP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_responder #(.DEPTH_WORDS(DW), .WAIT_CYCLES(WC)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] er, input logic ee);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = d; v.wstrb = s; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic do_txn(input vec_t v, input int idx);
    int k;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    chk({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = v.write;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_wstrb = v.wstrb;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = ~v.write;
    req_addr  = ~v.addr;
    req_wdata = ~v.wdata;
    req_wstrb = ~v.wstrb;
    chk({tag, "_ready_wait"}, 32'(req_ready), 32'd0);
    k = 1;
    while (!resp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, 32'(k), 32'(WC + 2));
    if (resp_valid) begin
      chk({tag, "_rdata"}, resp_rdata, v.exp_rdata);
      chk({tag, "_err"}, 32'(resp_err), 32'(v.exp_err));
    end
    @(negedge clk);
    chk({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t, first, second, nresp;
    logic [31:0] rd1, rd2;
    logic [31:0] word0;

    word0 = CHK ? 32'h0BADF00D : 32'h11223344;
    vecs[0]  = mk(1, 32'h0000_0100, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    vecs[1]  = mk(0, 32'h0000_0100, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0);
    vecs[2]  = mk(1, 32'h0000_0100, 32'h000000AA, 4'h1, 32'h0, 1'b0);
    vecs[3]  = mk(0, 32'h0000_0100, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0);
    vecs[4]  = mk(1, 32'h0000_0100, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
    vecs[5]  = mk(0, 32'h0000_0100, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0);
    vecs[6]  = mk(1, 32'h0000_0104, 32'h11111111, 4'hF, 32'h0, 1'b0);
    vecs[7]  = mk(1, 32'h0000_0104, 32'hAABBCCDD, 4'h6, 32'h0, 1'b0);
    vecs[8]  = mk(0, 32'h0000_0104, 32'h0,        4'h0, 32'h11BBCC11, 1'b0);
    vecs[9]  = mk(1, 32'h0000_0000, 32'h0BADF00D, 4'hF, 32'h0, 1'b0);
    vecs[10] = mk(1, 32'h0001_0000, 32'h11223344, 4'hF, 32'h0, CHK);
    vecs[11] = mk(0, 32'h0000_0000, 32'h0,        4'h0, word0, 1'b0);
    vecs[12] = mk(0, 32'h0000_0102, 32'h0,        4'h0, CHK ? 32'h0 : 32'hDEADBEAA, CHK);
    vecs[13] = mk(1, 32'h0000_FFFC, 32'h5A5AA5A5, 4'hF, 32'h0, 1'b0);
    vecs[14] = mk(0, 32'h0000_FFFC, 32'h0,        4'h0, 32'h5A5AA5A5, 1'b0);
    vecs[15] = mk(1, 32'h0000_0200, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; req_wstrb = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);

    for (int i = 0; i < 16; i++) do_txn(vecs[i], i);

    // Back-to-back: second load held during the first response.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h100; req_wstrb = 4'h0;
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h0;
    t = 1; first = 0; second = 0; rd1 = 32'd0; rd2 = 32'd0;
    while (second == 0 && t < 20) begin
      if (resp_valid) begin
        if (first == 0) begin
          first = t; rd1 = resp_rdata;
          chk("b2b_ready_in_resp", 32'(req_ready), 32'd1);
        end else begin
          second = t; rd2 = resp_rdata;
        end
      end
      if (first != 0 && t == first + 1) req_valid = 1'b0;
      @(negedge clk);
      t++;
    end
    req_valid = 1'b0;
    chk("b2b_first_time", 32'(first), 32'(WC + 2));
    chk("b2b_second_time", 32'(second), 32'(2 * (WC + 2)));
    chk("b2b_first_rdata", rd1, 32'hDEADBEAA);
    chk("b2b_second_rdata", rd2, word0);
    @(negedge clk);

    // Reset one cycle after accepting a store: store must be dropped.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h200;
    req_wdata = 32'h12345678; req_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstwait_ready", 32'(req_ready), 32'd1);
    nresp = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid) nresp++;
    end
    chk("rstwait_no_resp", 32'(nresp), 32'd0);
    do_txn(mk(0, 32'h200, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0), 100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
